// File: rtl/mips_pkg.sv
// Shared MIPS definitions: the HI/LO-class funct codes and the state
// encoding of the multiply/divide sequencer.
package mips_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DIV   = 2'd2,
    FIXUP = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration of the sequencer datapath.
// The 2*WIDTH accumulator is shared by both operations:
//   multiply: {partial_product, remaining_multiplier_bits}; add opnd when
//             the current LSB is set, then shift right by one.
//   divide:   {partial_remainder, dividend_bits -> quotient_bits}; shift
//             left by one, trial-subtract opnd, keep the result if it did
//             not go negative and shift the quotient bit in at the bottom.
module muldiv_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;

  // Shift-add and restore-subtract are both evaluated; is_div picks one.
  always_comb begin
    addend   = acc[0] ? opnd : '0;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    // The partial remainder is always below the divisor, so after the
    // shift it fits in WIDTH+1 bits and bit WIDTH of the difference is a
    // reliable borrow flag.
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd};
    acc_next = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!rem_diff[WIDTH]) begin
        acc_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hi_lo_muldiv_sequencer.sv
// HI/LO owner and multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the EX
// ALU. Operates on magnitudes for 32 cycles, applies signs in FIXUP and
// commits {hi,lo} at the end of FIXUP.
//
// Handshake: start is the "valid" of a HI/LO-class instruction in EX and
// !stall is its "ready". An instruction is consumed only on an edge where
// start=1 and the sequencer is IDLE; while busy, stall=start holds the
// pipeline so the same instruction is re-presented until the first IDLE
// cycle, where it is accepted and observes the committed hi/lo.
module hi_lo_muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  // Must equal WIDTH: one quotient/multiplier bit per iteration.
  parameter int ITERS = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [5:0]           funct,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  output logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo,
  output muldiv_state_t        state_dbg
);

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  muldiv_state_t       state;
  logic [CNT_W-1:0]    cnt;
  logic [2*WIDTH-1:0]  acc;
  logic [WIDTH-1:0]    opnd;
  logic                op_div;
  logic                neg_res;
  logic                neg_rem;
  logic                div_zero;

  logic                is_mul_op;
  logic                is_div_op;
  logic                is_signed;
  logic [WIDTH-1:0]    a_mag;
  logic [WIDTH-1:0]    b_mag;
  logic                res_sign;
  logic [2*WIDTH-1:0]  step_acc;
  logic [2*WIDTH-1:0]  prod_fix;
  logic [WIDTH-1:0]    quot_fix;
  logic [WIDTH-1:0]    rem_fix;

  // Decode the incoming funct and form operand magnitudes for acceptance.
  always_comb begin
    is_mul_op = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    is_div_op = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
    a_mag     = (is_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    b_mag     = (is_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    res_sign  = is_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
  end

  muldiv_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div   (op_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (step_acc)
  );

  // Sign restoration applied to the finished magnitude result in FIXUP.
  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Pipeline hold: any HI/LO-class instruction in EX while an op is in flight.
  always_comb begin
    stall     = busy & start;
    state_dbg = state;
  end

  // Sequencer FSM plus HI/LO, operand and accumulator registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul_op) begin
              acc      <= {{WIDTH{1'b0}}, b_mag};
              opnd     <= a_mag;
              neg_res  <= res_sign;
              neg_rem  <= 1'b0;
              op_div   <= 1'b0;
              div_zero <= 1'b0;
              cnt      <= '0;
              busy     <= 1'b1;
              state    <= MUL;
            end else if (is_div_op) begin
              op_div <= 1'b1;
              busy   <= 1'b1;
              if (operand_b == '0) begin
                // No iterations; FIXUP pulses done but leaves hi/lo alone.
                div_zero <= 1'b1;
                done     <= 1'b1;
                state    <= FIXUP;
              end else begin
                acc      <= {{WIDTH{1'b0}}, a_mag};
                opnd     <= b_mag;
                neg_res  <= res_sign;
                neg_rem  <= is_signed && operand_a[WIDTH-1];
                div_zero <= 1'b0;
                cnt      <= '0;
                state    <= DIV;
              end
            end else if (funct == FUNCT_MTHI) begin
              hi <= operand_a;
            end else if (funct == FUNCT_MTLO) begin
              lo <= operand_a;
            end
          end
        end
        MUL, DIV: begin
          acc <= step_acc;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            done  <= 1'b1;
            state <= FIXUP;
          end
        end
        FIXUP: begin
          if (!div_zero) begin
            if (op_div) begin
              hi <= rem_fix;
              lo <= quot_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hi_lo_muldiv_sequencer.sv
// Directed and randomised bench for hi_lo_muldiv_sequencer.
module tb_hi_lo_muldiv_sequencer;
  import mips_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [5:0]    funct;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic          stall;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  muldiv_state_t state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  hi_lo_muldiv_sequencer #(
    .WIDTH (W),
    .ITERS (W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .funct     (funct),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: returns {hi, lo}.
  function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      FUNCT_MULT:  ref_model = 64'(sa * sb);
      FUNCT_MULTU: ref_model = ua * ub;
      FUNCT_DIV: begin
        q = sa / sb;
        r = sa % sb;
        ref_model = {r[31:0], q[31:0]};
      end
      default: ref_model = {32'(a % b), 32'(a / b)};
    endcase
  endfunction

  // Driver: issue one instruction at the next edge (edge 0), then count
  // cycles until done is seen. Operand inputs are scrambled while busy.
  // Returns with time just after the commit edge.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    start = 1'b1; funct = f; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      operand_a = $urandom;
      operand_b = $urandom;
    end
    @(posedge clk); #1;
  endtask

  task automatic move_to(input logic [5:0] f, input logic [31:0] a);
    start = 1'b1; funct = f; operand_a = a; operand_b = '0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int cnt_stall;
    int cnt_done;
    logic [5:0] f;
    logic [31:0] a;
    logic [31:0] b;

    reset_n = 1'b0; start = 1'b0; funct = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);
    check("reset_stall", 64'(stall), 64'h0);
    check("reset_state", 64'(state_dbg), 64'(IDLE));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // MULTU max * max
    run_op(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("multu_lat", 64'(lat), 64'd33);
    check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(FUNCT_MULT, 32'hFFFF_FFF9, 32'd3, lat);
    check("mult_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_neg_lat", 64'(lat), 64'd33);
    check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // MTHI/MTLO preload, then divide by zero keeps them
    move_to(FUNCT_MTHI, 32'h1234);
    move_to(FUNCT_MTLO, 32'h5678);
    check("mt_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
    check("mt_busy", 64'(busy), 64'h0);
    run_op(FUNCT_DIVU, 32'd100, 32'd0, lat);
    check("div0_lat", 64'(lat), 64'd1);
    check("div0_busy_after", 64'(busy), 64'h0);
    check("div0_hilo", {hi, lo}, 64'h0000_1234_0000_5678);

    // Signed corner cases
    run_op(FUNCT_MULT, 32'h8000_0000, 32'h8000_0000, lat);
    check("mult_corner", {hi, lo}, 64'h4000_0000_0000_0000);
    run_op(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("div_corner", {hi, lo}, 64'h0000_0000_8000_0000);

    // MFLO held behind a MULT
    start = 1'b1; funct = FUNCT_MULT; operand_a = 32'd6; operand_b = 32'd7;
    @(posedge clk); #1;
    funct = FUNCT_MFLO;
    cnt_stall = 0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (stall) cnt_stall++;
    end
    check("mflo_stall_cycles", 64'(cnt_stall), 64'd33);
    @(negedge clk);
    check("mflo_stall_c34", 64'(stall), 64'h0);
    check("mflo_lo", 64'(lo), 64'd42);
    @(posedge clk); #1;
    start = 1'b0;

    // Back-to-back DIV held behind a MULT
    start = 1'b1; funct = FUNCT_MULT; operand_a = 32'd5; operand_b = 32'd5;
    @(posedge clk); #1;
    funct = FUNCT_DIV; operand_a = 32'd100; operand_b = 32'd7;
    cnt_stall = 0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (stall) cnt_stall++;
    end
    check("b2b_stall_cycles", 64'(cnt_stall), 64'd33);
    @(negedge clk);
    check("b2b_stall_c34", 64'(stall), 64'h0);
    check("b2b_mul_hilo", {hi, lo}, 64'd25);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    @(posedge clk); #1;
    check("b2b_div_lat", 64'(lat), 64'd33);
    check("b2b_div_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    // Unrelated funct is ignored
    start = 1'b1; funct = 6'b100000; operand_a = 32'd555; operand_b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("ignored_busy", 64'(busy), 64'h0);
    check("ignored_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    // Random sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0: f = FUNCT_MULT;
        1: f = FUNCT_MULTU;
        2: f = FUNCT_DIV;
        default: f = FUNCT_DIVU;
      endcase
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) b = -b;
      if (b == 0) b = 32'd1;
      exp_q.push_back(ref_model(f, a, b));
      run_op(f, a, b, lat);
      check("rand_lat", 64'(lat), 64'd33);
      check("rand_hilo", {hi, lo}, exp_q.pop_front());
    end

    // Reset in the middle of a DIV
    run_op(FUNCT_MULTU, 32'd3, 32'd3, lat);
    start = 1'b1; funct = FUNCT_DIV; operand_a = 32'd1000; operand_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_state", 64'(state_dbg), 64'(IDLE));
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_hilo", {hi, lo}, 64'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cnt_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) cnt_done++;
    end
    check("midrst_no_done", 64'(cnt_done), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
